// File: rtl/keccak_pkg.sv
// keccak_pkg: shared constants for the SHAKE/keccak wrapper family.
// Holds the run-controller state encodings (2-bit, legacy-compatible values)
// and the default core data width.
package keccak_pkg;

  localparam int unsigned CORE_W_DEF = 32;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_STOP  = 2'd2;
  localparam logic [1:0] ST_DRAIN = 2'd3;

endpackage

// File: rtl/shake_xof_if.sv
// shake_xof_if: host-side bus of the SHAKE XOF wrapper.
// Groups the run command, the message input stream and the digest output stream.
//   cmd_valid/cmd_ready/cmd_out_bits : run request with output length in bits
//   s_valid/s_ready/s_data           : message words towards the core
//   m_valid/m_ready/m_data/m_last    : packed digest words
// modport slave  : the wrapper side
// modport master : the host/DMA side
interface shake_xof_if
  import keccak_pkg::*;
#(
  parameter int unsigned CORE_W = CORE_W_DEF,
  parameter int unsigned OUT_W  = 2 * CORE_W_DEF,
  parameter int unsigned LEN_W  = 16
) ();

  logic              cmd_valid;
  logic              cmd_ready;
  logic [LEN_W-1:0]  cmd_out_bits;
  logic              s_valid;
  logic              s_ready;
  logic [CORE_W-1:0] s_data;
  logic              m_valid;
  logic              m_ready;
  logic [OUT_W-1:0]  m_data;
  logic              m_last;

  modport slave (
    input  cmd_valid, cmd_out_bits, s_valid, s_data, m_ready,
    output cmd_ready, s_ready, m_valid, m_data, m_last
  );

  modport master (
    output cmd_valid, cmd_out_bits, s_valid, s_data, m_ready,
    input  cmd_ready, s_ready, m_valid, m_data, m_last
  );

endinterface

// File: rtl/shake_out_gearbox.sv
// shake_out_gearbox: packs RATIO core words into one OUT_W digest word.
// First accepted core word lands in the LSBs. The completing word is loaded
// into the output register in the same cycle it arrives, so packing of the
// next word overlaps with emission of the current one.
// Ports:
//   clk, rst         clock, synchronous active-high reset
//   clr              drop any partial pack (outside RUN)
//   in_valid/in_data accepted core word
//   in_last          word being completed is the final digest word
//   tail_bits        cmd_out_bits mod OUT_W, used for final-word masking
//   m_ready          downstream ready
//   m_valid/m_data/m_last  registered digest word
//   load             pulse when a digest word is completed
// Build option: OUTPUT_MASK_EN zeroes final-word bits above tail_bits
// (no masking when tail_bits == 0); otherwise the final word is raw.
module shake_out_gearbox
  import keccak_pkg::*;
#(
  parameter int unsigned CORE_W = CORE_W_DEF,
  parameter int unsigned RATIO  = 2,
  parameter int unsigned LEN_W  = 16,
  parameter int unsigned OUT_W  = RATIO * CORE_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              in_valid,
  input  logic [CORE_W-1:0] in_data,
  input  logic              in_last,
  input  logic [LEN_W-1:0]  tail_bits,
  input  logic              m_ready,
  output logic              m_valid,
  output logic [OUT_W-1:0]  m_data,
  output logic              m_last,
  output logic              load
);

  localparam int unsigned PCNT_W = (RATIO > 1) ? $clog2(RATIO) : 1;

  logic [PCNT_W-1:0] pcnt;
  logic [OUT_W-1:0]  pack;
  logic [OUT_W-1:0]  full;
  logic [OUT_W-1:0]  word_mask;

  // Current pack contents with the arriving word dropped into its slot.
  always_comb begin
    full = pack;
    full[pcnt*CORE_W +: CORE_W] = in_data;
  end

  assign load = in_valid && (pcnt == PCNT_W'(RATIO - 1));

`ifdef OUTPUT_MASK_EN
  always_comb begin
    word_mask = '1;
    if (in_last && (tail_bits != '0))
      word_mask = ~({OUT_W{1'b1}} << tail_bits);
  end
`else
  logic unused_tail;
  assign unused_tail = ^tail_bits;
  assign word_mask   = '1;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      pcnt    <= '0;
      pack    <= '0;
      m_valid <= 1'b0;
      m_data  <= '0;
      m_last  <= 1'b0;
    end else begin
      if (clr) begin
        pcnt <= '0;
      end else if (in_valid) begin
        pack <= full;
        pcnt <= load ? '0 : pcnt + 1'b1;
      end
      if (load) begin
        m_valid <= 1'b1;
        m_data  <= full & word_mask;
        m_last  <= in_last;
      end else if (m_ready) begin
        m_valid <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/shake_xof_top.sv
// shake_xof_top: run controller around one keccak core.
// Passes the message stream straight to the core, packs core output words
// into OUT_W = RATIO*CORE_W digest words, counts requested output words and
// ends each run itself through core_force_done / core_force_done_ack.
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   bus                 shake_xof_if.slave: cmd_*, s_*, m_* streams
//   busy                controller not idle
//   core_din_*          message stream to the core
//   core_dout_*         output stream from the core
//   core_force_done     stop request to the core (held in STOP)
//   core_force_done_ack core acknowledge of the stop request
// Build option: OUTPUT_MASK_EN masks the final digest word to the requested
// bit length (see shake_out_gearbox).
module shake_xof_top
  import keccak_pkg::*;
#(
  parameter int unsigned CORE_W = CORE_W_DEF,
  parameter int unsigned RATIO  = 2,
  parameter int unsigned LEN_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  shake_xof_if.slave        bus,
  output logic              busy,
  output logic              core_din_valid,
  input  logic              core_din_ready,
  output logic [CORE_W-1:0] core_din,
  input  logic              core_dout_valid,
  output logic              core_dout_ready,
  input  logic [CORE_W-1:0] core_dout,
  output logic              core_force_done,
  input  logic              core_force_done_ack
);

  localparam int unsigned OUT_W    = RATIO * CORE_W;
  localparam int unsigned OUT_SH   = $clog2(OUT_W);
  localparam bit          OUT_POW2 = ((OUT_W & (OUT_W - 1)) == 0);

  logic [1:0]       state;
  logic [LEN_W-1:0] out_words;
  logic [LEN_W-1:0] word_cnt;
  logic [LEN_W-1:0] tail_bits;
  logic [LEN_W-1:0] cmd_words;
  logic [LEN_W-1:0] cmd_tail;
  logic [LEN_W:0]   bits_up;
  logic             run;
  logic             in_fire;
  logic             last_word;
  logic             load;
  logic             m_valid;
  logic             m_last;
  logic [OUT_W-1:0] m_data;

  // ceil(cmd_out_bits / OUT_W); one extra bit keeps the round-up from wrapping.
  always_comb begin
    bits_up = {1'b0, bus.cmd_out_bits} + (LEN_W+1)'(OUT_W - 1);
    if (OUT_POW2)
      cmd_words = LEN_W'(bits_up >> OUT_SH);
    else
      cmd_words = LEN_W'(bits_up / (LEN_W+1)'(OUT_W));
    cmd_tail = LEN_W'(bus.cmd_out_bits % OUT_W);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      out_words <= '0;
      word_cnt  <= '0;
      tail_bits <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (bus.cmd_valid) begin
            out_words <= cmd_words;
            tail_bits <= cmd_tail;
            word_cnt  <= '0;
            state     <= (cmd_words == '0) ? ST_STOP : ST_RUN;
          end
        end
        ST_RUN: begin
          if (load)
            word_cnt <= word_cnt + 1'b1;
          if (m_valid && bus.m_ready && m_last)
            state <= ST_STOP;
        end
        ST_STOP: begin
          if (core_force_done_ack)
            state <= ST_DRAIN;
        end
        ST_DRAIN: begin
          if (!core_force_done_ack)
            state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  always_comb begin
    run             = (state == ST_RUN);
    bus.cmd_ready   = (state == ST_IDLE);
    busy            = (state != ST_IDLE);
    core_din_valid  = run && bus.s_valid;
    bus.s_ready     = run && core_din_ready;
    core_din        = bus.s_data;
    core_force_done = (state == ST_STOP);
    case (state)
      ST_RUN:            core_dout_ready = !m_valid || bus.m_ready;
      ST_STOP, ST_DRAIN: core_dout_ready = 1'b1;
      default:           core_dout_ready = 1'b0;
    endcase
    last_word = (word_cnt == out_words - 1'b1);
    // Once every requested word is loaded, further core words are dropped.
    in_fire   = run && core_dout_valid && core_dout_ready && (word_cnt != out_words);
  end

  shake_out_gearbox #(
    .CORE_W (CORE_W),
    .RATIO  (RATIO),
    .LEN_W  (LEN_W),
    .OUT_W  (OUT_W)
  ) u_gearbox (
    .clk       (clk),
    .rst       (rst),
    .clr       (!run),
    .in_valid  (in_fire),
    .in_data   (core_dout),
    .in_last   (last_word),
    .tail_bits (tail_bits),
    .m_ready   (bus.m_ready),
    .m_valid   (m_valid),
    .m_data    (m_data),
    .m_last    (m_last),
    .load      (load)
  );

  assign bus.m_valid = m_valid;
  assign bus.m_data  = m_data;
  assign bus.m_last  = m_last;

endmodule

// File: tb/tb_shake_xof_top.sv
// tb_shake_xof_top: scoreboard bench for shake_xof_top (CORE_W=32, RATIO=2).
// Expected digest words are queued when core words are scheduled and popped
// when the DUT completes an m_* handshake. A simple core model returns queued
// words and acknowledges force_done two cycles later.
module tb_shake_xof_top;
  import keccak_pkg::*;

  localparam int unsigned CORE_W = 32;
  localparam int unsigned RATIO  = 2;
  localparam int unsigned LEN_W  = 16;
  localparam int unsigned OUT_W  = RATIO * CORE_W;

  typedef struct {
    logic [OUT_W-1:0] data;
    logic             last;
  } exp_t;

  logic              clk;
  logic              rst;
  logic              busy;
  logic              core_din_valid;
  logic              core_din_ready;
  logic [CORE_W-1:0] core_din;
  logic              core_dout_valid;
  logic              core_dout_ready;
  logic [CORE_W-1:0] core_dout;
  logic              core_force_done;
  logic              core_force_done_ack;

  shake_xof_if #(.CORE_W(CORE_W), .OUT_W(OUT_W), .LEN_W(LEN_W)) bus ();

  shake_xof_top #(
    .CORE_W (CORE_W),
    .RATIO  (RATIO),
    .LEN_W  (LEN_W)
  ) dut (
    .clk                 (clk),
    .rst                 (rst),
    .bus                 (bus),
    .busy                (busy),
    .core_din_valid      (core_din_valid),
    .core_din_ready      (core_din_ready),
    .core_din            (core_din),
    .core_dout_valid     (core_dout_valid),
    .core_dout_ready     (core_dout_ready),
    .core_dout           (core_dout),
    .core_force_done     (core_force_done),
    .core_force_done_ack (core_force_done_ack)
  );

  int n_checks = 0;
  int n_errors = 0;

  exp_t              exp_q[$];
  logic [CORE_W-1:0] core_q[$];

  logic             core_fire;
  logic             fd_s;
  logic             ack_d1;
  logic             hold_v;
  logic [OUT_W-1:0] hold_d;
  logic             stop_pend;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
    n_checks++;
    if (got !== want) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, want);
    end
  endtask

  function automatic logic [CORE_W-1:0] gen_word(input int mode, input logic [CORE_W-1:0] base,
                                                 input int unsigned k);
    if (mode == 0) return base + CORE_W'(k);
    else if (mode == 1) return CORE_W'($urandom);
    else return '1;
  endfunction

  // Schedule core output words for one run and the digest words they produce.
  task automatic push_run(input int unsigned bits, input int mode, input logic [CORE_W-1:0] base);
    int unsigned       nw;
    logic [CORE_W-1:0] lo, hi;
    exp_t              e;
    nw = (bits + OUT_W - 1) / OUT_W;
    for (int unsigned i = 0; i < nw; i++) begin
      lo = gen_word(mode, base, 2 * i);
      hi = gen_word(mode, base, 2 * i + 1);
      core_q.push_back(lo);
      core_q.push_back(hi);
      e.data = {hi, lo};
      e.last = (i == nw - 1);
`ifdef OUTPUT_MASK_EN
      if (e.last && (bits % OUT_W) != 0)
        e.data = e.data & ((64'd1 << (bits % OUT_W)) - 64'd1);
`endif
      exp_q.push_back(e);
    end
  endtask

  task automatic issue_cmd(input int unsigned bits);
    @(posedge clk); #1;
    bus.cmd_valid    = 1'b1;
    bus.cmd_out_bits = bits[LEN_W-1:0];
    @(negedge clk);
    chk("cmd_ready_idle", 64'(bus.cmd_ready), 64'd1);
    @(posedge clk); #1;
    bus.cmd_valid = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int n;
    n = 0;
    @(negedge clk);
    while (busy && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk("idle_timeout", 64'(busy), 64'd0);
  endtask

  // Core model: return queued words, ack force_done two cycles later.
  initial begin
    core_dout_valid     = 1'b0;
    core_dout           = '0;
    core_force_done_ack = 1'b0;
    ack_d1              = 1'b0;
    forever begin
      @(posedge clk);
      if (core_fire && core_q.size() > 0) void'(core_q.pop_front());
      #1;
      core_force_done_ack = ack_d1;
      ack_d1              = fd_s;
      core_dout_valid     = (core_q.size() > 0);
      core_dout           = (core_q.size() > 0) ? core_q[0] : '0;
    end
  end

  // Monitor: scoreboard compare, hold stability, STOP after last word.
  initial begin
    exp_t e;
    core_fire = 1'b0;
    fd_s      = 1'b0;
    hold_v    = 1'b0;
    hold_d    = '0;
    stop_pend = 1'b0;
    forever begin
      @(negedge clk);
      core_fire = core_dout_valid && core_dout_ready;
      fd_s      = core_force_done;
      if (rst) begin
        hold_v    = 1'b0;
        stop_pend = 1'b0;
        continue;
      end
      if (stop_pend) begin
        chk("stop_after_last", 64'(core_force_done), 64'd1);
        stop_pend = 1'b0;
      end
      if (hold_v) begin
        chk("m_data_hold", bus.m_data, hold_d);
        chk("m_valid_hold", 64'(bus.m_valid), 64'd1);
      end
      if (bus.m_valid && !bus.m_ready) begin
        hold_v = 1'b1;
        hold_d = bus.m_data;
        chk("dout_stall", 64'(core_dout_ready), 64'd0);
      end else begin
        hold_v = 1'b0;
      end
      if (bus.m_valid && bus.m_ready) begin
        if (exp_q.size() == 0) begin
          chk("extra_word", 64'(bus.m_valid), 64'd0);
        end else begin
          e = exp_q.pop_front();
          chk("m_data", bus.m_data, e.data);
          chk("m_last", 64'(bus.m_last), 64'(e.last));
          if (bus.m_last) stop_pend = 1'b1;
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog checks=%0d", n_checks);
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    rst              = 1'b1;
    bus.cmd_valid    = 1'b0;
    bus.cmd_out_bits = '0;
    bus.s_valid      = 1'b0;
    bus.s_data       = '0;
    bus.m_ready      = 1'b1;
    core_din_ready   = 1'b1;

    // Reset state
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("rst_cmd_ready", 64'(bus.cmd_ready), 64'd1);
    chk("rst_m_valid", 64'(bus.m_valid), 64'd0);
    chk("rst_force_done", 64'(core_force_done), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_dout_ready", 64'(core_dout_ready), 64'd0);
    chk("rst_s_ready", 64'(bus.s_ready), 64'd0);

    // 128-bit run, words 1..4, two late words to be discarded
    push_run(128, 0, 32'd1);
    core_q.push_back(32'hDEAD_0001);
    core_q.push_back(32'hDEAD_0002);
    issue_cmd(128);
    @(posedge clk); #1;
    bus.s_valid = 1'b1;
    bus.s_data  = 32'hA5A5_0001;
    @(negedge clk);
    chk("run_busy", 64'(busy), 64'd1);
    chk("s_ready_pass", 64'(bus.s_ready), 64'd1);
    chk("din_valid_pass", 64'(core_din_valid), 64'd1);
    chk("din_data_pass", 64'(core_din), 64'h0000_0000_A5A5_0001);
    @(posedge clk); #1;
    core_din_ready = 1'b0;
    @(negedge clk);
    chk("s_ready_block", 64'(bus.s_ready), 64'd0);
    @(posedge clk); #1;
    bus.s_valid    = 1'b0;
    core_din_ready = 1'b1;
    bus.cmd_valid  = 1'b1;
    bus.cmd_out_bits = 16'd64;
    @(negedge clk);
    chk("cmd_ready_busy", 64'(bus.cmd_ready), 64'd0);
    @(posedge clk); #1;
    bus.cmd_valid = 1'b0;
    wait_idle(40);
    chk("run1_words_left", 64'(exp_q.size()), 64'd0);
    chk("run1_late_drained", 64'(core_q.size()), 64'd0);

    // Zero-length run: straight to STOP, handshake with the core only
    issue_cmd(0);
    @(negedge clk);
    chk("zero_force_done", 64'(core_force_done), 64'd1);
    chk("zero_busy", 64'(busy), 64'd1);
    n = 0;
    while (core_force_done && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("zero_fd_release", 64'(core_force_done), 64'd0);
    chk("zero_drain_busy", 64'(busy), 64'd1);
    chk("zero_drain_ack", 64'(core_force_done_ack), 64'd1);
    wait_idle(20);
    chk("zero_cmd_ready", 64'(bus.cmd_ready), 64'd1);

    // Backpressure: m_ready low 5 cycles with a word pending
    push_run(256, 1, '0);
    issue_cmd(256);
    n = 0;
    @(negedge clk);
    while (!bus.m_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    @(posedge clk); #1;
    bus.m_ready = 1'b0;
    n = 0;
    @(negedge clk);
    while (!bus.m_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("bp_pending", 64'(bus.m_valid), 64'd1);
    for (int i = 0; i < 5; i++) begin
      chk("bp_dout_ready", 64'(core_dout_ready), 64'd0);
      @(negedge clk);
    end
    @(posedge clk); #1;
    bus.m_ready = 1'b1;
    wait_idle(60);
    chk("bp_words_left", 64'(exp_q.size()), 64'd0);
    chk("bp_core_left", 64'(core_q.size()), 64'd0);

    // 40-bit request: final word masked or raw depending on build
    push_run(40, 2, '0);
    issue_cmd(40);
    wait_idle(40);
    chk("mask_words_left", 64'(exp_q.size()), 64'd0);

    // Reset mid-run after one core word, then a clean 64-bit run
    core_q.push_back(32'h1111_1111);
    issue_cmd(128);
    n = 0;
    while (core_q.size() > 0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("midrst_word_taken", 64'(core_q.size()), 64'd0);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("midrst_busy", 64'(busy), 64'd0);
    chk("midrst_force_done", 64'(core_force_done), 64'd0);
    chk("midrst_cmd_ready", 64'(bus.cmd_ready), 64'd1);
    chk("midrst_m_valid", 64'(bus.m_valid), 64'd0);
    core_q.delete();
    exp_q.delete();
    push_run(64, 0, 32'h0000_00A0);
    issue_cmd(64);
    wait_idle(40);
    chk("post_rst_words_left", 64'(exp_q.size()), 64'd0);

    repeat (3) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
